sram_2rw_ctrl: RTL and testbench

- Single-clock controller that shares the two RW ports of the 2-port 64x128 OpenRAM macro (sky130_sram_2rw_64x128_64) between two clients, A and B.
- Client A is routed to port 0 and client B to port 1. The block resolves same-address write/read and write/write collisions with round-robin priority.
- After reset, or on request, it runs a fill sequence that writes INIT_VALUE to every word.
- Read data returns through registered response ports, one cycle after the request is accepted.
- Sits between the core/DMA request logic and the macro instance.

---
 rtl/sram_2rw_ctrl.sv | 158 +++++++++++++++
 tb/tb_sram_2rw_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_2rw_ctrl.sv
// Two-client controller for the 2RW 64x128 OpenRAM macro: client A on port 0,
// client B on port 1, round-robin collision arbitration and an INIT_VALUE fill.
module sram_2rw_ctrl #(
  parameter int                    DATA_WIDTH    = 64,
  parameter int                    ADDR_WIDTH    = 7,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
  parameter bit                    INIT_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_start,
  output logic                  init_busy,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic                  sram_web1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  output logic [DATA_WIDTH-1:0] sram_din1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic [15:0]           conflict_cnt
);

  localparam logic [0:0]            ST_RUN  = 1'b0;
  localparam logic [0:0]            ST_INIT = 1'b1;
  localparam logic [ADDR_WIDTH-2:0] K_LAST  = '1;

  logic [0:0]            state_reg;
  logic                  boot_reg;
  logic [ADDR_WIDTH-2:0] fill_k_reg;
  logic                  rr_ptr_reg;
  logic [15:0]           conflict_cnt_reg;

  logic run, collision, a_acc, b_acc;
  logic p0_en, p0_we, p1_en, p1_we;
  logic [ADDR_WIDTH-1:0] p0_addr, p1_addr;
  logic [DATA_WIDTH-1:0] p0_din, p1_din;

  assign run       = (state_reg == ST_RUN);
  assign init_busy = (state_reg == ST_INIT);
  assign collision = a_req_valid & b_req_valid & (a_req_addr == b_req_addr)
                   & (a_req_we | b_req_we);

  // rr_ptr_reg == 0 favours A; only matters on a collision.
  assign a_req_ready = run & (~collision | ~rr_ptr_reg);
  assign b_req_ready = run & (~collision | rr_ptr_reg);
  assign a_acc       = a_req_valid & a_req_ready;
  assign b_acc       = b_req_valid & b_req_ready;

  always_comb begin
    p0_en = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_din = '0;
    p1_en = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_din = '0;
    if (state_reg == ST_INIT) begin
      // Both halves filled in parallel: port 0 the low half, port 1 the high half.
      p0_en = 1'b1; p0_we = 1'b1; p0_addr = {1'b0, fill_k_reg}; p0_din = INIT_VALUE;
      p1_en = 1'b1; p1_we = 1'b1; p1_addr = {1'b1, fill_k_reg}; p1_din = INIT_VALUE;
    end else begin
      if (a_acc) begin
        p0_en = 1'b1; p0_we = a_req_we; p0_addr = a_req_addr;
        p0_din = a_req_we ? a_req_wdata : '0;
      end
      if (b_acc) begin
        p1_en = 1'b1; p1_we = b_req_we; p1_addr = b_req_addr;
        p1_din = b_req_we ? b_req_wdata : '0;
      end
    end
  end

  assign sram_csb0  = ~(p0_en & rst_n);
  assign sram_web0  = ~p0_we;
  assign sram_addr0 = p0_addr;
  assign sram_din0  = p0_din;
  assign sram_csb1  = ~(p1_en & rst_n);
  assign sram_web1  = ~p1_we;
  assign sram_addr1 = p1_addr;
  assign sram_din1  = p1_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_RUN;
      boot_reg         <= INIT_ON_RESET;
      fill_k_reg       <= '0;
      rr_ptr_reg       <= 1'b0;
      conflict_cnt_reg <= '0;
    end else begin
      boot_reg <= 1'b0;
      if (state_reg == ST_INIT) begin
        fill_k_reg <= fill_k_reg + 1'b1;
        if (fill_k_reg == K_LAST) begin
          state_reg  <= ST_RUN;
          fill_k_reg <= '0;
        end
      end else begin
        if (boot_reg || init_start) state_reg <= ST_INIT;
        if (collision) begin
          rr_ptr_reg <= ~rr_ptr_reg;
          if (conflict_cnt_reg != 16'hFFFF) conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
      end
    end
  end

  assign conflict_cnt = conflict_cnt_reg;

  // Read response path, one identical slice per client.
  logic [1:0]            rd_acc;
  logic [DATA_WIDTH-1:0] rd_dout  [2];
  logic [1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata[2];

  assign rd_acc[0]  = a_acc & ~a_req_we;
  assign rd_acc[1]  = b_acc & ~b_req_we;
  assign rd_dout[0] = sram_dout0;
  assign rd_dout[1] = sram_dout1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      logic                  pend_reg;
      logic                  valid_reg;
      logic [DATA_WIDTH-1:0] rdata_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_reg  <= 1'b0;
          valid_reg <= 1'b0;
          rdata_reg <= '0;
        end else begin
          pend_reg  <= rd_acc[gi];
          valid_reg <= pend_reg;
          if (pend_reg) rdata_reg <= rd_dout[gi];
        end
      end
      assign rsp_valid[gi] = valid_reg;
      assign rsp_rdata[gi] = rdata_reg;
    end
  endgenerate

  assign a_rsp_valid = rsp_valid[0];
  assign a_rsp_rdata = rsp_rdata[0];
  assign b_rsp_valid = rsp_valid[1];
  assign b_rsp_rdata = rsp_rdata[1];

endmodule

// File: tb/tb_sram_2rw_ctrl.sv
// Directed bench for sram_2rw_ctrl with a behavioural model of the 2RW macro.
module tb_sram_2rw_ctrl;

  logic        clk;
  logic        rst_n;
  logic        init_start;
  logic        init_busy;
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [6:0]  a_req_addr;
  logic [63:0] a_req_wdata;
  logic        a_rsp_valid;
  logic [63:0] a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [6:0]  b_req_addr;
  logic [63:0] b_req_wdata;
  logic        b_rsp_valid;
  logic [63:0] b_rsp_rdata;
  logic        sram_csb0, sram_web0, sram_csb1, sram_web1;
  logic [6:0]  sram_addr0, sram_addr1;
  logic [63:0] sram_din0, sram_din1, sram_dout0, sram_dout1;
  logic [15:0] conflict_cnt;

  int vec = 0;
  int miscompares = 0;

  sram_2rw_ctrl dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_busy(init_busy),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_web1(sram_web1), .sram_addr1(sram_addr1),
    .sram_din1(sram_din1), .sram_dout1(sram_dout1),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: inputs sampled on the rising edge, read data valid after it.
  logic [63:0] mem [0:127];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) mem[sram_addr0] <= sram_din0;
      else            sram_dout0      <= mem[sram_addr0];
    end
    if (!sram_csb1) begin
      if (!sram_web1) mem[sram_addr1] <= sram_din1;
      else            sram_dout1      <= mem[sram_addr1];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0;
    init_start = 0;
  endtask

  // Follows the fill from the next falling edge; checks macro pins each busy cycle.
  task automatic watch_fill(input int k0, input int abort_at,
                            output int k, output int bad, output int rsp_seen);
    logic [6:0] e0, e1;
    k = k0; bad = 0; rsp_seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (a_rsp_valid || b_rsp_valid) rsp_seen++;
      if (init_busy) begin
        e0 = 7'(k);
        e1 = 7'(k + 64);
        if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== e0 || sram_din0 !== 64'h0 ||
            sram_csb1 !== 1'b0 || sram_web1 !== 1'b0 || sram_addr1 !== e1 || sram_din1 !== 64'h0 ||
            a_req_ready !== 1'b0 || b_req_ready !== 1'b0) bad++;
        k++;
        if (k == abort_at) return;
      end else if (k > k0) begin
        return;
      end
    end
  endtask

  task automatic check_fill(input string name, input int k, input int bad, input int rsp_seen);
    vec++;
    if (k !== 64) begin miscompares++; $display("FAIL %s_len: got %0d cycles, expected 64", name, k); end
    vec++;
    if (bad !== 0) begin miscompares++; $display("FAIL %s_pins: got %0d bad cycles, expected 0", name, bad); end
    vec++;
    if (rsp_seen !== 0) begin miscompares++; $display("FAIL %s_rsp: got %0d rsp_valid cycles, expected 0", name, rsp_seen); end
    $display("fill %s: %0d cycles, %0d pin errors", name, k, bad);
  endtask

  task automatic a_read(input logic [6:0] addr, input logic [63:0] exp, input string name);
    a_req_valid = 1; a_req_we = 0; a_req_addr = addr; #1;
    vec++;
    if (a_req_ready !== 1'b1) begin miscompares++; $display("FAIL %s_ready: got %b expected 1", name, a_req_ready); end
    @(negedge clk); a_req_valid = 0; #1;
    vec++;
    if (a_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL %s_early: got rsp_valid %b expected 0", name, a_rsp_valid); end
    @(negedge clk); #1;
    vec++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== exp) begin
      miscompares++;
      $display("FAIL %s_data: got valid %b data %h expected valid 1 data %h", name, a_rsp_valid, a_rsp_rdata, exp);
    end
    $display("A read [%0d] -> %h", addr, a_rsp_rdata);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int k, bad, rs;
    idle();
    rst_n = 1; #1 rst_n = 0;
    @(negedge clk); @(negedge clk); #1;
    vec++;
    if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin
      miscompares++; $display("FAIL reset_csb: got %b%b expected 11", sram_csb0, sram_csb1);
    end
    vec++;
    if (init_busy !== 1'b0 || a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0 || conflict_cnt !== 16'h0 ||
        a_rsp_rdata !== 64'h0 || b_rsp_rdata !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got busy %b rv %b%b cnt %h expected 0 00 0000", init_busy, a_rsp_valid, b_rsp_valid, conflict_cnt);
    end
    $display("reset applied");
    rst_n = 1;
    watch_fill(0, -1, k, bad, rs);
    check_fill("por", k, bad, rs);
    a_read(7'd0,   64'h0, "fill_rd0");
    a_read(7'd63,  64'h0, "fill_rd63");
    a_read(7'd64,  64'h0, "fill_rd64");
    a_read(7'd127, 64'h0, "fill_rd127");
  endtask

  task automatic test_raw();
    a_req_valid = 1; a_req_we = 1; a_req_addr = 7'd5; a_req_wdata = 64'hDEAD_BEEF_0123_4567; #1;
    vec++;
    if (a_req_ready !== 1'b1) begin miscompares++; $display("FAIL raw_wr_ready: got %b expected 1", a_req_ready); end
    @(negedge clk);
    a_req_we = 0; b_req_valid = 1; b_req_we = 0; b_req_addr = 7'd5; #1;
    vec++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
      miscompares++; $display("FAIL raw_rd_ready: got %b%b expected 11", a_req_ready, b_req_ready);
    end
    @(negedge clk); a_req_valid = 0; b_req_valid = 0; #1;
    vec++;
    if (a_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL raw_early: got %b expected 0", a_rsp_valid); end
    @(negedge clk); #1;
    vec++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 64'hDEAD_BEEF_0123_4567) begin
      miscompares++; $display("FAIL raw_a_data: got %b %h expected 1 deadbeef01234567", a_rsp_valid, a_rsp_rdata);
    end
    vec++;
    if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 64'hDEAD_BEEF_0123_4567) begin
      miscompares++; $display("FAIL raw_b_data: got %b %h expected 1 deadbeef01234567", b_rsp_valid, b_rsp_rdata);
    end
    $display("write/read [5] -> A %h B %h", a_rsp_rdata, b_rsp_rdata);
    @(negedge clk); #1;
    vec++;
    if (a_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL raw_pulse: got %b expected 0", a_rsp_valid); end
  endtask

  task automatic test_same_read();
    a_req_valid = 1; a_req_we = 1; a_req_addr = 7'd7; a_req_wdata = 64'h0707_0707_A5A5_5A5A;
    @(negedge clk);
    a_req_we = 0; b_req_valid = 1; b_req_we = 0; b_req_addr = 7'd7; #1;
    vec++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
      miscompares++; $display("FAIL rr_same_ready: got %b%b expected 11", a_req_ready, b_req_ready);
    end
    @(negedge clk); idle();
    @(negedge clk); #1;
    vec++;
    if (a_rsp_valid !== 1'b1 || b_rsp_valid !== 1'b1 || a_rsp_rdata !== 64'h0707_0707_A5A5_5A5A ||
        b_rsp_rdata !== 64'h0707_0707_A5A5_5A5A) begin
      miscompares++; $display("FAIL rr_same_data: got %b %h %b %h expected 1 07070707a5a55a5a twice",
                              a_rsp_valid, a_rsp_rdata, b_rsp_valid, b_rsp_rdata);
    end
    vec++;
    if (conflict_cnt !== 16'd0) begin miscompares++; $display("FAIL rr_same_cnt: got %0d expected 0", conflict_cnt); end
    $display("dual read [7] -> %h / %h", a_rsp_rdata, b_rsp_rdata);
    @(negedge clk);
  endtask

  task automatic test_wr_rd_conflict();
    a_req_valid = 1; a_req_we = 1; a_req_addr = 7'd9; a_req_wdata = 64'h9999_0000_1111_2222;
    b_req_valid = 1; b_req_we = 0; b_req_addr = 7'd9; #1;
    vec++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0) begin
      miscompares++; $display("FAIL wr_cf_grant1: got %b%b expected 10", a_req_ready, b_req_ready);
    end
    @(negedge clk); a_req_valid = 0; #1;
    vec++;
    if (b_req_ready !== 1'b1) begin miscompares++; $display("FAIL wr_cf_grant2: got %b expected 1", b_req_ready); end
    @(negedge clk); b_req_valid = 0; #1;
    vec++;
    if (b_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL wr_cf_early: got %b expected 0", b_rsp_valid); end
    @(negedge clk); #1;
    vec++;
    if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 64'h9999_0000_1111_2222) begin
      miscompares++; $display("FAIL wr_cf_data: got %b %h expected 1 9999000011112222", b_rsp_valid, b_rsp_rdata);
    end
    vec++;
    if (conflict_cnt !== 16'd1) begin miscompares++; $display("FAIL wr_cf_cnt: got %0d expected 1", conflict_cnt); end
    $display("write/read conflict [9] -> B %h cnt %0d", b_rsp_rdata, conflict_cnt);
    // Pointer now favours B.
    a_req_valid = 1; a_req_we = 0; a_req_addr = 7'd9;
    b_req_valid = 1; b_req_we = 1; b_req_addr = 7'd9; b_req_wdata = 64'h1; #1;
    vec++;
    if (a_req_ready !== 1'b0 || b_req_ready !== 1'b1) begin
      miscompares++; $display("FAIL wr_cf_rrptr: got %b%b expected 01", a_req_ready, b_req_ready);
    end
    @(negedge clk); idle(); #1;
    vec++;
    if (conflict_cnt !== 16'd2) begin miscompares++; $display("FAIL wr_cf_cnt2: got %0d expected 2", conflict_cnt); end
    @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    int k, bad, rs;
    a_req_valid = 1; a_req_we = 0; a_req_addr = 7'd5;
    @(negedge clk); a_req_valid = 0; #1;
    rst_n = 0; #1;
    vec++;
    if (a_rsp_valid !== 1'b0 || sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1 || conflict_cnt !== 16'd0) begin
      miscompares++; $display("FAIL inflight_rst: got rv %b csb %b%b cnt %0d expected 0 11 0",
                              a_rsp_valid, sram_csb0, sram_csb1, conflict_cnt);
    end
    @(negedge clk); #1;
    vec++;
    if (a_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL inflight_drop: got %b expected 0", a_rsp_valid); end
    rst_n = 1;
    watch_fill(0, -1, k, bad, rs);
    check_fill("inflight", k, bad, rs);
  endtask

  task automatic test_ww_conflict();
    a_req_valid = 1; a_req_we = 1; a_req_addr = 7'd3; a_req_wdata = 64'hAAAA_AAAA_0000_0003;
    b_req_valid = 1; b_req_we = 1; b_req_addr = 7'd3; b_req_wdata = 64'hBBBB_BBBB_0000_0003; #1;
    vec++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0) begin
      miscompares++; $display("FAIL ww_grant1: got %b%b expected 10", a_req_ready, b_req_ready);
    end
    @(negedge clk); #1;
    vec++;
    if (a_req_ready !== 1'b0 || b_req_ready !== 1'b1) begin
      miscompares++; $display("FAIL ww_grant2: got %b%b expected 01", a_req_ready, b_req_ready);
    end
    @(negedge clk); idle(); #1;
    vec++;
    if (conflict_cnt !== 16'd2) begin miscompares++; $display("FAIL ww_cnt: got %0d expected 2", conflict_cnt); end
    $display("write/write conflict [3] cnt %0d", conflict_cnt);
    a_read(7'd3, 64'hBBBB_BBBB_0000_0003, "ww_final");
  endtask

  task automatic test_fill_abort();
    int k, bad, rs;
    idle();
    rst_n = 0; @(negedge clk); rst_n = 1;
    a_req_valid = 1; a_req_we = 0; a_req_addr = 7'd5;
    watch_fill(0, 30, k, bad, rs);
    vec++;
    if (k !== 30 || bad !== 0) begin miscompares++; $display("FAIL abort_pre: got k %0d bad %0d expected 30 0", k, bad); end
    rst_n = 0; #1;
    vec++;
    if (init_busy !== 1'b0 || sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1 || a_rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL abort_rst: got busy %b csb %b%b rv %b expected 0 11 0",
                              init_busy, sram_csb0, sram_csb1, a_rsp_valid);
    end
    @(negedge clk); idle(); rst_n = 1;
    watch_fill(0, -1, k, bad, rs);
    check_fill("abort", k, bad, rs);
  endtask

  task automatic test_init_start();
    int k, bad, rs;
    a_req_valid = 1; a_req_we = 1; a_req_addr = 7'd100; a_req_wdata = 64'h1234;
    @(negedge clk); idle();
    init_start = 1; @(posedge clk); #1 init_start = 0;
    watch_fill(0, 10, k, bad, rs);
    init_start = 1; @(posedge clk); #1 init_start = 0;
    watch_fill(k, -1, k, bad, rs);
    check_fill("manual", k, bad, rs);
    @(negedge clk); #1;
    vec++;
    if (init_busy !== 1'b0) begin miscompares++; $display("FAIL init_ignored: got busy %b expected 0", init_busy); end
    a_read(7'd100, 64'h0, "manual_rd100");
  endtask

  initial begin
    test_reset();
    test_raw();
    test_same_read();
    test_wr_rd_conflict();
    test_reset_inflight();
    test_ww_conflict();
    test_fill_abort();
    test_init_start();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end

endmodule
